// File: rtl/penc_pkg.sv
// Shared types and helpers for the penc_stream priority encoder.
package penc_pkg;

    // Widest request vector the multi-hot helper can inspect.
    localparam int unsigned MAX_WIDTH = 64;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 8;

    // Index width for a w-bit request vector; never narrower than one bit.
    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

    localparam int unsigned DEF_IDX_W = idx_width(DEF_WIDTH);

    typedef logic [DEF_IDX_W-1:0] idx_t;
    typedef logic [DEF_CNT_W-1:0] cnt_t;

    // True when more than one bit of vec is set (clearing the lowest set bit leaves a residue).
    function automatic logic onehot_multi(input logic [MAX_WIDTH-1:0] vec);
        return (vec & (vec - MAX_WIDTH'(1))) != '0;
    endfunction

endpackage

// File: rtl/penc_stream_if.sv
// Valid/ready stream bundle for penc_stream: request input, encoded result output,
// and the multi-hot error counter with its clear.
interface penc_stream_if
    import penc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) ();

    localparam int unsigned IDX_W = idx_width(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [IDX_W-1:0] out_idx;
    logic             out_any;
    logic             out_multi;
    logic [CNT_W-1:0] err_cnt;
    logic             err_clr;

    // Encoder side.
    modport slave (
        input  in_valid, in_data, out_ready, err_clr,
        output in_ready, out_valid, out_idx, out_any, out_multi, err_cnt
    );

    // Producer/consumer side.
    modport master (
        output in_valid, in_data, out_ready, err_clr,
        input  in_ready, out_valid, out_idx, out_any, out_multi, err_cnt
    );

endinterface

// File: rtl/penc_core.sv
// Combinational priority search: first set bit at or above ptr_i, wrapping past
// WIDTH-1 to 0. With ptr_i tied to 0 this is plain lowest-index priority.
module penc_core
    import penc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned IDX_W = idx_width(WIDTH)
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o,
    output logic             multi_o
);

    int unsigned pos;
    logic        found;

    // Scan WIDTH positions starting at ptr_i; the first hit wins.
    always_comb begin
        idx_o   = '0;
        found   = 1'b0;
        pos     = 0;
        any_o   = |data_i;
        multi_o = onehot_multi(MAX_WIDTH'(data_i));
        for (int unsigned k = 0; k < WIDTH; k++) begin
            pos = 32'(ptr_i) + k;
            if (pos >= WIDTH) begin
                pos = pos - WIDTH;
            end
            if (!found && data_i[pos[IDX_W-1:0]]) begin
                idx_o = pos[IDX_W-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/penc_stream.sv
// Registered priority encoder with valid/ready handshake and a saturating
// multi-hot error counter. Define PENC_ROUND_ROBIN_EN for rotating priority.
module penc_stream
    import penc_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 8
) (
    input  logic         clk,
    input  logic         rst,
    penc_stream_if.slave bus
);

    localparam int unsigned IDX_W = idx_width(WIDTH);

    logic             in_ready;
    logic             accept;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] core_idx;
    logic             core_any;
    logic             core_multi;

    logic             out_valid_q;
    logic [IDX_W-1:0] idx_q;
    logic             any_q;
    logic             multi_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign in_ready = !out_valid_q || bus.out_ready;
    assign accept   = bus.in_valid && in_ready;

    penc_core #(
        .WIDTH (WIDTH),
        .IDX_W (IDX_W)
    ) u_core (
        .data_i  (bus.in_data),
        .ptr_i   (ptr),
        .idx_o   (core_idx),
        .any_o   (core_any),
        .multi_o (core_multi)
    );

`ifdef PENC_ROUND_ROBIN_EN
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] ptr_d;

    // Advance the start position past the winner; explicit wrap keeps non-power-of-2 widths in range.
    always_comb begin
        ptr_d = ptr_q;
        if (accept && core_any) begin
            ptr_d = (core_idx == IDX_W'(WIDTH - 1)) ? '0 : core_idx + IDX_W'(1);
        end
    end

    // Rotating priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;
`else
    assign ptr = '0;
`endif

    // Clear takes effect before the increment, so clear plus a multi-hot accept yields 1.
    always_comb begin
        cnt_d = bus.err_clr ? '0 : cnt_q;
        if (accept && core_multi && (cnt_d != '1)) begin
            cnt_d = cnt_d + CNT_W'(1);
        end
    end

    // Multi-hot error counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Output pipeline register: load on accept, drop valid once taken, fields hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            idx_q       <= '0;
            any_q       <= 1'b0;
            multi_q     <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            idx_q       <= core_idx;
            any_q       <= core_any;
            multi_q     <= core_multi;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_idx   = idx_q;
    assign bus.out_any   = any_q;
    assign bus.out_multi = multi_q;
    assign bus.err_cnt   = cnt_q;

endmodule

// File: tb/tb_penc_stream.sv
// Directed self-checking bench for penc_stream (8-bit, 8-bit with 2-bit counter, 5-bit).
module tb_penc_stream;

    logic clk;
    logic rst;
    int   asserts;
    int   fails;

    penc_stream_if #(.WIDTH(8), .CNT_W(8)) b8 ();
    penc_stream_if #(.WIDTH(8), .CNT_W(2)) bs ();
    penc_stream_if #(.WIDTH(5), .CNT_W(8)) b5 ();

    penc_stream #(.WIDTH(8), .CNT_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));
    penc_stream #(.WIDTH(8), .CNT_W(2)) u_duts (.clk(clk), .rst(rst), .bus(bs));
    penc_stream #(.WIDTH(5), .CNT_W(8)) u_dut5 (.clk(clk), .rst(rst), .bus(b5));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi} !== 6'b0) begin
            fails++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi});
        end
        asserts++;
        if (b8.err_cnt !== 8'd0 || bs.err_cnt !== 2'd0) begin
            fails++;
            $display("FAIL reset_err_cnt: got %0d/%0d expected 0/0", b8.err_cnt, bs.err_cnt);
        end
        asserts++;
        if (b8.in_ready !== 1'b1 || b5.out_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_ready: in_ready=%b b5.out_valid=%b expected 1/0",
                     b8.in_ready, b5.out_valid);
        end
        #10 rst = 1'b0;
    endtask

    task automatic test_single();
        b8.in_valid  = 1'b1;
        b8.in_data   = 8'h80;
        b8.out_ready = 1'b1;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi} !== {1'b1, 3'd7, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL single_0x80: got v=%b idx=%0d any=%b multi=%b expected v=1 idx=7 any=1 multi=0",
                     b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi);
        end
        b8.in_valid = 1'b0;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any} !== {1'b0, 3'd7, 1'b1}) begin
            fails++;
            $display("FAIL single_drain: got v=%b idx=%0d any=%b expected v=0 idx=7 any=1",
                     b8.out_valid, b8.out_idx, b8.out_any);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] vec [3];
        logic [2:0] exp_idx [3];
        vec     = '{8'h01, 8'h02, 8'h04};
        exp_idx = '{3'd0, 3'd1, 3'd2};
        for (int i = 0; i < 3; i++) begin
            b8.in_valid = 1'b1;
            b8.in_data  = vec[i];
            #1;
            asserts++;
            if (b8.in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", i, b8.in_ready);
            end
            tick();
            asserts++;
            if ({b8.out_valid, b8.out_idx, b8.out_multi} !== {1'b1, exp_idx[i], 1'b0}) begin
                fails++;
                $display("FAIL b2b_idx[%0d]: got v=%b idx=%0d multi=%b expected v=1 idx=%0d multi=0",
                         i, b8.out_valid, b8.out_idx, b8.out_multi, exp_idx[i]);
            end
        end
        b8.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        b8.in_valid  = 1'b1;
        b8.in_data   = 8'h10;
        b8.out_ready = 1'b1;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx} !== {1'b1, 3'd4}) begin
            fails++;
            $display("FAIL bp_first: got v=%b idx=%0d expected v=1 idx=4", b8.out_valid, b8.out_idx);
        end
        b8.out_ready = 1'b0;
        b8.in_data   = 8'h20;
        for (int i = 0; i < 3; i++) begin
            tick();
            asserts++;
            if ({b8.out_valid, b8.out_idx, b8.out_any, b8.in_ready} !== {1'b1, 3'd4, 1'b1, 1'b0}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got v=%b idx=%0d any=%b in_ready=%b expected v=1 idx=4 any=1 in_ready=0",
                         i, b8.out_valid, b8.out_idx, b8.out_any, b8.in_ready);
            end
        end
        b8.out_ready = 1'b1;
        #1;
        asserts++;
        if (b8.in_ready !== 1'b1) begin
            fails++;
            $display("FAIL bp_release_ready: got %b expected 1", b8.in_ready);
        end
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx} !== {1'b1, 3'd5}) begin
            fails++;
            $display("FAIL bp_next: got v=%b idx=%0d expected v=1 idx=5", b8.out_valid, b8.out_idx);
        end
        b8.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_empty_multi();
        b8.in_valid = 1'b1;
        b8.in_data  = 8'h00;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi} !== {1'b1, 3'd0, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL empty: got v=%b idx=%0d any=%b multi=%b expected v=1 idx=0 any=0 multi=0",
                     b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi);
        end
        b8.in_data = 8'h28;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi} !== {1'b1, 3'd3, 1'b1, 1'b1}) begin
            fails++;
            $display("FAIL multi_0x28: got v=%b idx=%0d any=%b multi=%b expected v=1 idx=3 any=1 multi=1",
                     b8.out_valid, b8.out_idx, b8.out_any, b8.out_multi);
        end
        asserts++;
        if (b8.err_cnt !== 8'd1) begin
            fails++;
            $display("FAIL multi_err_cnt: got %0d expected 1", b8.err_cnt);
        end
        b8.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        logic [7:0] vec [5];
        logic [1:0] exp_cnt [5];
        vec     = '{8'h03, 8'h06, 8'h28, 8'hFF, 8'h81};
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        bs.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bs.in_valid = 1'b1;
            bs.in_data  = vec[i];
            tick();
            asserts++;
            if ({bs.err_cnt, bs.out_multi} !== {exp_cnt[i], 1'b1}) begin
                fails++;
                $display("FAIL sat_cnt[%0d]: got cnt=%0d multi=%b expected cnt=%0d multi=1",
                         i, bs.err_cnt, bs.out_multi, exp_cnt[i]);
            end
        end
        bs.err_clr = 1'b1;
        bs.in_data = 8'h0C;
        tick();
        asserts++;
        if (bs.err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL clr_with_multi: got %0d expected 1", bs.err_cnt);
        end
        bs.in_valid = 1'b0;
        tick();
        asserts++;
        if (bs.err_cnt !== 2'd0) begin
            fails++;
            $display("FAIL clr_alone: got %0d expected 0", bs.err_cnt);
        end
        bs.err_clr = 1'b0;
    endtask

    task automatic test_width5();
`ifdef PENC_ROUND_ROBIN_EN
        localparam int N = 11;
        logic [4:0] vec [N];
        logic [3:0] exp [N];
        vec = '{5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h01, 5'h00, 5'h1F};
        exp = '{{3'd0, 1'b1}, {3'd1, 1'b1}, {3'd2, 1'b1}, {3'd3, 1'b1}, {3'd4, 1'b1},
                {3'd0, 1'b1}, {3'd1, 1'b1}, {3'd2, 1'b1}, {3'd0, 1'b1}, {3'd0, 1'b0},
                {3'd1, 1'b1}};
`else
        localparam int N = 5;
        logic [4:0] vec [N];
        logic [3:0] exp [N];
        vec = '{5'h1F, 5'h14, 5'h10, 5'h18, 5'h00};
        exp = '{{3'd0, 1'b1}, {3'd2, 1'b1}, {3'd4, 1'b1}, {3'd3, 1'b1}, {3'd0, 1'b0}};
`endif
        b5.out_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            b5.in_valid = 1'b1;
            b5.in_data  = vec[i];
            tick();
            asserts++;
            if ({b5.out_valid, b5.out_idx, b5.out_any} !== {1'b1, exp[i]}) begin
                fails++;
                $display("FAIL w5_vec[%0d]=%b: got v=%b idx=%0d any=%b expected v=1 idx=%0d any=%b",
                         i, vec[i], b5.out_valid, b5.out_idx, b5.out_any, exp[i][3:1], exp[i][0]);
            end
        end
        b5.in_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        b8.in_valid  = 1'b1;
        b8.in_data   = 8'h40;
        b8.out_ready = 1'b0;
        tick();
        b8.in_valid = 1'b0;
        asserts++;
        if ({b8.out_valid, b8.out_idx} !== {1'b1, 3'd6}) begin
            fails++;
            $display("FAIL ar_loaded: got v=%b idx=%0d expected v=1 idx=6", b8.out_valid, b8.out_idx);
        end
        #2 rst = 1'b1;
        #1;
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.err_cnt} !== {1'b1 ^ 1'b1, 3'd0, 8'd0}) begin
            fails++;
            $display("FAIL ar_immediate: got v=%b idx=%0d err=%0d expected v=0 idx=0 err=0",
                     b8.out_valid, b8.out_idx, b8.err_cnt);
        end
        b8.in_valid  = 1'b1;
        b8.in_data   = 8'h04;
        b8.out_ready = 1'b1;
        @(posedge clk);
        #3 rst = 1'b0;
        tick();
        asserts++;
        if ({b8.out_valid, b8.out_idx, b8.out_any} !== {1'b1, 3'd2, 1'b1}) begin
            fails++;
            $display("FAIL ar_first_after: got v=%b idx=%0d any=%b expected v=1 idx=2 any=1",
                     b8.out_valid, b8.out_idx, b8.out_any);
        end
        b8.in_valid = 1'b0;
        tick();
    endtask

    initial begin
        asserts = 0;
        fails   = 0;
        rst     = 1'b1;
        b8.in_valid = 1'b0; b8.in_data = '0; b8.out_ready = 1'b1; b8.err_clr = 1'b0;
        bs.in_valid = 1'b0; bs.in_data = '0; bs.out_ready = 1'b1; bs.err_clr = 1'b0;
        b5.in_valid = 1'b0; b5.in_data = '0; b5.out_ready = 1'b1; b5.err_clr = 1'b0;

        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_empty_multi();
        test_saturate();
        test_width5();
        test_async_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
